// File: rtl/cia_timer_bank.sv
// CIA-style interval timer bank: CHANNELS down-counters with reload latches,
// one-shot/continuous modes, CNT and cascade count sources, and an ICR interrupt block.
module cia_timer_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                CLK_2,
  input  logic                _RES,
  input  logic                CNT,
  input  logic                _CS,
  input  logic                R_W,
  input  logic [3:0]          RS,
  input  logic [7:0]          DI,
  output logic [7:0]          DO,
  output logic                _IRQ,
  output logic [CHANNELS-1:0] PULSE
);

  logic [CHANNELS-1:0][WIDTH-1:0] latch_reg;
  logic [CHANNELS-1:0][WIDTH-1:0] counter_reg;
  logic [CHANNELS-1:0][WIDTH-1:0] latch_wr_val;
  logic [CHANNELS-1:0][1:0]       inmode_reg;
  logic [CHANNELS-1:0][7:0]       cnt_hi;
  logic [CHANNELS-1:0]            start_reg;
  logic [CHANNELS-1:0]            oneshot_reg;
  logic [CHANNELS-1:0]            flags_reg;
  logic [CHANNELS-1:0]            mask_reg;
  logic [CHANNELS-1:0]            latch_wr;
  logic [CHANNELS-1:0]            reload_wr;
  logic [CHANNELS-1:0]            cr_wr;
  logic [CHANNELS-1:0]            load_strobe;
  logic [CHANNELS-1:0]            en;
  logic [CHANNELS-1:0]            pulse;
  logic                           cnt_prev_reg;
  logic                           cnt_rise;
  logic                           bus_wr;
  logic                           bus_rd;
  logic                           icr_wr;
  logic                           icr_rd;
  logic                           any_irq;
  logic [3:0]                     flags_ext;
  logic [7:0]                     rd_data;

  assign bus_wr    = !_CS && !R_W;
  assign bus_rd    = !_CS && R_W;
  assign icr_wr    = bus_wr && (RS == 4'hD);
  assign icr_rd    = bus_rd && (RS == 4'hD);
  assign cnt_rise  = CNT && !cnt_prev_reg;
  assign any_irq   = |(flags_reg & mask_reg);
  assign flags_ext = 4'(flags_reg);
  assign PULSE     = pulse;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic en_c;
      logic pulse_c;

      assign cr_wr[gi]       = bus_wr && (RS == 4'(8 + gi));
      assign load_strobe[gi] = cr_wr[gi] && DI[3];

      if (WIDTH == 8) begin : g_w8
        assign latch_wr[gi]     = bus_wr && (RS == 4'(2 * gi));
        assign reload_wr[gi]    = latch_wr[gi];
        assign latch_wr_val[gi] = DI;
        assign cnt_hi[gi]       = 8'h00;
      end else begin : g_w16
        logic lo_wr;
        logic hi_wr;
        assign lo_wr            = bus_wr && (RS == 4'(2 * gi));
        assign hi_wr            = bus_wr && (RS == 4'(2 * gi + 1));
        assign latch_wr[gi]     = lo_wr || hi_wr;
        assign reload_wr[gi]    = hi_wr;
        assign latch_wr_val[gi] = hi_wr ? {DI, latch_reg[gi][7:0]} : {latch_reg[gi][15:8], DI};
        assign cnt_hi[gi]       = counter_reg[gi][15:8];
      end

      // Channel 0 has no predecessor, so the cascade modes fall back to every-cycle counting.
      if (gi == 0) begin : g_first
        assign en_c = start_reg[gi] && ((inmode_reg[gi] == 2'b01) ? cnt_rise : 1'b1);
      end else begin : g_casc
        logic src;
        always_comb begin
          src = 1'b1;
          case (inmode_reg[gi])
            2'b01:   src = cnt_rise;
            2'b10:   src = g_ch[gi-1].pulse_c;
            2'b11:   src = g_ch[gi-1].pulse_c && CNT;
            default: src = 1'b1;
          endcase
        end
        assign en_c = start_reg[gi] && src;
      end

      // A LOAD strobe pre-empts the underflow, so no strobe or flag is produced.
      assign pulse_c   = en_c && (counter_reg[gi] == '0) && !load_strobe[gi];
      assign en[gi]    = en_c;
      assign pulse[gi] = pulse_c;
    end
  endgenerate

  always_comb begin
    rd_data = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      if (RS == 4'(2 * c))     rd_data = counter_reg[c][7:0];
      if (RS == 4'(2 * c + 1)) rd_data = cnt_hi[c];
      if (RS == 4'(8 + c))     rd_data = {2'b00, inmode_reg[c], 2'b00, oneshot_reg[c], start_reg[c]};
    end
    if (RS == 4'hD) rd_data = {any_irq, 3'b000, flags_ext};
  end

  always_ff @(posedge CLK_2 or negedge _RES) begin
    if (!_RES) begin
      latch_reg    <= '1;
      counter_reg  <= '1;
      start_reg    <= '0;
      oneshot_reg  <= '0;
      inmode_reg   <= '0;
      flags_reg    <= '0;
      mask_reg     <= '0;
      cnt_prev_reg <= 1'b0;
      DO           <= 8'h00;
      _IRQ         <= 1'b1;
    end else begin
      cnt_prev_reg <= CNT;
      for (int c = 0; c < CHANNELS; c++) begin
        if (latch_wr[c]) latch_reg[c] <= latch_wr_val[c];

        if (load_strobe[c] || pulse[c])        counter_reg[c] <= latch_reg[c];
        else if (en[c])                        counter_reg[c] <= counter_reg[c] - WIDTH'(1);
        else if (reload_wr[c] && !start_reg[c]) counter_reg[c] <= latch_wr_val[c];

        if (cr_wr[c]) begin
          start_reg[c]   <= DI[0];
          oneshot_reg[c] <= DI[1];
          inmode_reg[c]  <= DI[5:4];
        end else if (pulse[c] && oneshot_reg[c]) begin
          start_reg[c] <= 1'b0;
        end
      end

      // Underflows in the read cycle survive the clear-on-read.
      flags_reg <= (icr_rd ? '0 : flags_reg) | pulse;

      if (icr_wr) begin
        if (DI[7]) mask_reg <= mask_reg | DI[CHANNELS-1:0];
        else       mask_reg <= mask_reg & ~DI[CHANNELS-1:0];
      end

      if (bus_rd) DO <= rd_data;
      _IRQ <= !any_irq;
    end
  end

endmodule

// File: tb/tb_cia_timer_bank.sv
// Directed bench for cia_timer_bank (WIDTH=16, CHANNELS=2) with hand-computed expectations.
module tb_cia_timer_bank;

  logic       CLK_2 = 1'b0;
  logic       _RES  = 1'b0;
  logic       CNT   = 1'b0;
  logic       _CS   = 1'b1;
  logic       R_W   = 1'b1;
  logic [3:0] RS    = 4'h0;
  logic [7:0] DI    = 8'h00;
  logic [7:0] DO;
  logic       _IRQ;
  logic [1:0] PULSE;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK_2 = ~CLK_2;

  cia_timer_bank #(.WIDTH(16), .CHANNELS(2)) dut (
    .CLK_2 (CLK_2),
    ._RES  (_RES),
    .CNT   (CNT),
    ._CS   (_CS),
    .R_W   (R_W),
    .RS    (RS),
    .DI    (DI),
    .DO    (DO),
    ._IRQ  (_IRQ),
    .PULSE (PULSE)
  );

  task automatic tick();
    @(posedge CLK_2);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] rs, input logic [7:0] data);
    _CS = 1'b0; R_W = 1'b0; RS = rs; DI = data;
    tick();
    _CS = 1'b1; R_W = 1'b1;
    $display("wr rs=%h di=%h", rs, data);
  endtask

  task automatic bus_read(input logic [3:0] rs, output logic [7:0] data);
    _CS = 1'b0; R_W = 1'b1; RS = rs;
    tick();
    _CS = 1'b1;
    data = DO;
    $display("rd rs=%h do=%h", rs, data);
  endtask

  task automatic chk_rd(input string name, input logic [3:0] rs, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(rs, d);
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL %s: rs=%h got %h want %h", name, rs, d, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(posedge CLK_2);
    #1 _RES = 1'b1;
    vectors++;
    if ({DO, _IRQ, PULSE} !== {8'h00, 1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_state: got do=%h irq=%b pulse=%b want 00/1/00", DO, _IRQ, PULSE);
    end
    bus_write(4'h0, 8'h05);
    bus_write(4'h1, 8'h00);
    bus_write(4'h8, 8'h01);
    bus_read(4'h0, d);
    vectors++;
    if (d !== 8'h05) begin
      miscompares++;
      $display("FAIL count_before_reset: got %h want 05", d);
    end
    tick();
    @(negedge CLK_2);
    #2 _RES = 1'b0;
    #1;
    vectors++;
    if ({DO, _IRQ, PULSE} !== {8'h00, 1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL async_reset: got do=%h irq=%b pulse=%b want 00/1/00", DO, _IRQ, PULSE);
    end
    @(posedge CLK_2);
    #1 _RES = 1'b1;
    chk_rd("reset_cnt_lo", 4'h0, 8'hFF);
    chk_rd("reset_cnt_hi", 4'h1, 8'hFF);
    chk_rd("reset_cr0", 4'h8, 8'h00);
    chk_rd("reset_icr", 4'hD, 8'h00);
    bus_write(4'h0, 8'h34);
    chk_rd("lo_write_no_load", 4'h0, 8'hFF);
    bus_write(4'h1, 8'h12);
    chk_rd("hi_write_load_lo", 4'h0, 8'h34);
    chk_rd("hi_write_load_hi", 4'h1, 8'h12);
    bus_write(4'h9, 8'hFF);
    chk_rd("cr1_readback", 4'h9, 8'h33);
    bus_write(4'h9, 8'h00);
    chk_rd("unmapped_read", 4'hE, 8'h00);
  endtask

  task automatic test_continuous();
    bus_write(4'h0, 8'h03);
    bus_write(4'h1, 8'h00);
    bus_write(4'h8, 8'h09);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK_2);
      vectors++;
      if (PULSE !== {1'b0, (k % 4) == 0}) begin
        miscompares++;
        $display("FAIL continuous_pulse: cycle %0d got %b want %b", k, PULSE, {1'b0, (k % 4) == 0});
      end
    end
    chk_rd("continuous_icr", 4'hD, 8'h01);
    bus_write(4'h8, 8'h00);
    chk_rd("continuous_icr_retained", 4'hD, 8'h01);
    chk_rd("continuous_icr_cleared", 4'hD, 8'h00);
  endtask

  task automatic test_oneshot();
    bus_write(4'h0, 8'h02);
    bus_write(4'h1, 8'h00);
    bus_write(4'h8, 8'h0B);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK_2);
      vectors++;
      if (PULSE !== {1'b0, k == 3}) begin
        miscompares++;
        $display("FAIL oneshot_pulse: cycle %0d got %b want %b", k, PULSE, {1'b0, k == 3});
      end
    end
    chk_rd("oneshot_cr0", 4'h8, 8'h02);
    chk_rd("oneshot_icr", 4'hD, 8'h01);
  endtask

  task automatic test_cascade();
    logic [1:0] exp;
    bus_write(4'h0, 8'h01);
    bus_write(4'h1, 8'h00);
    bus_write(4'h2, 8'h02);
    bus_write(4'h3, 8'h00);
    bus_write(4'h8, 8'h09);
    bus_write(4'h9, 8'h29);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK_2);
      exp = {(k == 5) || (k == 11), (k % 2) == 1};
      vectors++;
      if (PULSE !== exp) begin
        miscompares++;
        $display("FAIL cascade_pulse: cycle %0d got %b want %b", k, PULSE, exp);
      end
    end
    bus_write(4'h8, 8'h00);
    bus_write(4'h9, 8'h00);
    chk_rd("cascade_icr", 4'hD, 8'h03);
  endtask

  task automatic test_cnt_source();
    bus_write(4'h2, 8'h02);
    bus_write(4'h3, 8'h00);
    bus_write(4'h9, 8'h19);
    for (int i = 0; i < 3; i++) begin
      CNT = 1'b1;
      @(negedge CLK_2);
      vectors++;
      if (PULSE !== {i == 2, 1'b0}) begin
        miscompares++;
        $display("FAIL cnt_edge_pulse: edge %0d got %b want %b", i, PULSE, {i == 2, 1'b0});
      end
      tick();
      CNT = 1'b0;
      tick();
    end
    bus_write(4'h9, 8'h00);
    chk_rd("cnt_icr", 4'hD, 8'h02);
  endtask

  task automatic test_irq();
    bus_write(4'hD, 8'h81);
    bus_write(4'h0, 8'h01);
    bus_write(4'h1, 8'h00);
    bus_write(4'h8, 8'h0B);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK_2);
      vectors++;
      if (_IRQ !== (k < 4)) begin
        miscompares++;
        $display("FAIL irq_assert: cycle %0d got %b want %b", k, _IRQ, k < 4);
      end
    end
    chk_rd("irq_icr", 4'hD, 8'h81);
    @(negedge CLK_2);
    vectors++;
    if (_IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_hold: got %b want 0", _IRQ);
    end
    @(negedge CLK_2);
    vectors++;
    if (_IRQ !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_release: got %b want 1", _IRQ);
    end
    chk_rd("irq_icr_cleared", 4'hD, 8'h00);
    bus_write(4'hD, 8'h01);
  endtask

  task automatic test_collision();
    bus_write(4'h0, 8'h01);
    bus_write(4'h1, 8'h00);
    bus_write(4'h8, 8'h0B);
    tick();
    chk_rd("collision_read", 4'hD, 8'h00);
    chk_rd("collision_retained", 4'hD, 8'h01);
    chk_rd("collision_cleared", 4'hD, 8'h00);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_cascade();
    test_cnt_source();
    test_irq();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
